// File: rtl/pipe_scoreboard.sv
// ============================================================================
// pipe_scoreboard : RAW hazard controller with EX/MEM/WB shadow tag pipeline
// Revision 1.0
// ============================================================================
`default_nettype none

module pipe_scoreboard #(
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             dec_valid_i,
   input  logic [7:0]       dec_src_i,
   input  logic [1:0]       dec_src_en_i,
   input  logic [3:0]       dec_dst_i,
   input  logic [1:0]       dec_wr_i,
   input  logic [3:0]       dec_bank_i,
   input  logic             mem_hold_i,
   input  logic             flush_i,
   output logic             stall_o,
   output logic             hazard_o,
   output logic             issue_o,
   output logic [15:0]      busy_o,
   output logic [CNT_W-1:0] stall_cnt_o
);

   // Index 0 = S1 (EX), 1 = S2 (MEM), 2 = S3 (WB)
   logic [2:0]       v_q, v_d;
   logic [2:0][3:0]  dst_q, dst_d;
   logic [2:0][3:0]  bank_q, bank_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [15:0] busy;
   logic        hazard;
   logic        stall;
   logic        issue;

   // WB is included because the register file does not bypass writes to reads
   always_comb begin
      busy = '0;
      for (int r = 0; r < 16; r++) begin
         for (int k = 0; k < 3; k++) begin
            if (v_q[k] && (dst_q[k] == 4'(r)) && (bank_q[k] == dec_bank_i)) begin
               busy[r] = 1'b1;
            end
         end
      end
   end

   always_comb begin
      hazard = dec_valid_i && !flush_i &&
               ((dec_src_en_i[0] && busy[dec_src_i[3:0]]) ||
                (dec_src_en_i[1] && busy[dec_src_i[7:4]]));
      stall  = hazard || mem_hold_i;
      issue  = dec_valid_i && !stall && !flush_i;
   end

   always_comb begin
      v_d    = v_q;
      dst_d  = dst_q;
      bank_d = bank_q;
      cnt_d  = cnt_q;
      if (!mem_hold_i) begin
         v_d[2]    = v_q[1];
         dst_d[2]  = dst_q[1];
         bank_d[2] = bank_q[1];
         v_d[1]    = v_q[0];
         dst_d[1]  = dst_q[0];
         bank_d[1] = bank_q[0];
         v_d[0]    = issue && (dec_wr_i != 2'b00);
         dst_d[0]  = dec_dst_i;
         bank_d[0] = dec_bank_i;
         if (hazard && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         v_q    <= '0;
         dst_q  <= '0;
         bank_q <= '0;
         cnt_q  <= '0;
      end else begin
         v_q    <= v_d;
         dst_q  <= dst_d;
         bank_q <= bank_d;
         cnt_q  <= cnt_d;
      end
   end

   assign stall_o     = stall;
   assign hazard_o    = hazard;
   assign issue_o     = issue;
   assign busy_o      = busy;
   assign stall_cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_scoreboard.sv
// ============================================================================
// tb_pipe_scoreboard : scoreboard bench for pipe_scoreboard (16- and 4-bit counters)
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_pipe_scoreboard;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        dec_valid_i = 1'b0;
   logic [7:0]  dec_src_i = '0;
   logic [1:0]  dec_src_en_i = '0;
   logic [3:0]  dec_dst_i = '0;
   logic [1:0]  dec_wr_i = '0;
   logic [3:0]  dec_bank_i = '0;
   logic        mem_hold_i = 1'b0;
   logic        flush_i = 1'b0;

   logic        stall_o, hazard_o, issue_o;
   logic [15:0] busy_o;
   logic [15:0] stall_cnt_o;
   logic        stall2, hazard2, issue2;
   logic [15:0] busy2;
   logic [3:0]  cnt2;

   typedef struct {
      logic        haz;
      logic        iss;
      logic        stl;
      logic [15:0] busy;
      int          cnt;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk_i = ~clk_i;

   pipe_scoreboard #(.CNT_W(16)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .dec_valid_i(dec_valid_i), .dec_src_i(dec_src_i),
      .dec_src_en_i(dec_src_en_i), .dec_dst_i(dec_dst_i), .dec_wr_i(dec_wr_i),
      .dec_bank_i(dec_bank_i), .mem_hold_i(mem_hold_i), .flush_i(flush_i),
      .stall_o(stall_o), .hazard_o(hazard_o), .issue_o(issue_o), .busy_o(busy_o),
      .stall_cnt_o(stall_cnt_o)
   );

   pipe_scoreboard #(.CNT_W(4)) dut4 (
      .clk_i(clk_i), .rst_i(rst_i), .dec_valid_i(dec_valid_i), .dec_src_i(dec_src_i),
      .dec_src_en_i(dec_src_en_i), .dec_dst_i(dec_dst_i), .dec_wr_i(dec_wr_i),
      .dec_bank_i(dec_bank_i), .mem_hold_i(mem_hold_i), .flush_i(flush_i),
      .stall_o(stall2), .hazard_o(hazard2), .issue_o(issue2), .busy_o(busy2),
      .stall_cnt_o(cnt2)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Monitor: one expected record per cycle, compared mid-cycle
   always @(negedge clk_i) begin
      if (q.size() != 0) begin
         exp_t e;
         e = q.pop_front();
         chk("hazard_o", int'(hazard_o), int'(e.haz));
         chk("issue_o",  int'(issue_o),  int'(e.iss));
         chk("stall_o",  int'(stall_o),  int'(e.stl));
         chk("busy_o",   int'(busy_o),   int'(e.busy));
         chk("stall_cnt_o", int'(stall_cnt_o), e.cnt);
         chk("stall_cnt_o_w4", int'(cnt2), (e.cnt > 15) ? 15 : e.cnt);
         chk("hazard_o_w4", int'(hazard2), int'(e.haz));
      end
   end

   task automatic step(input logic v, input logic [3:0] s1, input logic [3:0] s2,
                       input logic [1:0] en, input logic [3:0] dst, input logic [1:0] wr,
                       input logic [3:0] bank, input logic hold, input logic flush,
                       input logic rst, input logic ehaz, input logic eiss,
                       input logic [15:0] ebusy, input int ecnt);
      exp_t e;
      @(posedge clk_i);
      #1;
      rst_i        = rst;
      dec_valid_i  = v;
      dec_src_i    = {s2, s1};
      dec_src_en_i = en;
      dec_dst_i    = dst;
      dec_wr_i     = wr;
      dec_bank_i   = bank;
      mem_hold_i   = hold;
      flush_i      = flush;
      e.haz  = ehaz;
      e.iss  = eiss;
      e.stl  = ehaz | hold;
      e.busy = ebusy;
      e.cnt  = ecnt;
      q.push_back(e);
   endtask

   task automatic idle(input logic [3:0] bank, input logic [15:0] ebusy, input int ecnt);
      step(1'b0, 4'd0, 4'd0, 2'b00, 4'd0, 2'b00, bank, 1'b0, 1'b0, 1'b0,
           1'b0, 1'b0, ebusy, ecnt);
   endtask

   // Producer r3 <- r1, then non-writing reader of r3: three hazard cycles
   task automatic sat_chain(input int b);
      step(1'b1, 4'd1, 4'd0, 2'b01, 4'd3, 2'b01, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, b);
      step(1'b1, 4'd3, 4'd0, 2'b01, 4'd4, 2'b00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0008, b);
      step(1'b1, 4'd3, 4'd0, 2'b01, 4'd4, 2'b00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0008, b + 1);
      step(1'b1, 4'd3, 4'd0, 2'b01, 4'd4, 2'b00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0008, b + 2);
      step(1'b1, 4'd3, 4'd0, 2'b01, 4'd4, 2'b00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, b + 3);
   endtask

   initial begin
      // Reset then idle
      step(1'b0, 4'd0, 4'd0, 2'b00, 4'd0, 2'b00, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 0);
      for (int i = 0; i < 5; i++) idle(4'd0, 16'h0000, 0);

      // RAW chain bank 0: r3 <- r1, r4 <- r3
      step(1'b1, 4'd1, 4'd0, 2'b01, 4'd3, 2'b01, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 0);
      step(1'b1, 4'd3, 4'd0, 2'b01, 4'd4, 2'b01, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0008, 0);
      step(1'b1, 4'd3, 4'd0, 2'b01, 4'd4, 2'b01, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0008, 1);
      step(1'b1, 4'd3, 4'd0, 2'b01, 4'd4, 2'b01, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0008, 2);
      step(1'b1, 4'd3, 4'd0, 2'b01, 4'd4, 2'b01, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 3);
      idle(4'd0, 16'h0010, 3);
      idle(4'd0, 16'h0010, 3);
      idle(4'd0, 16'h0010, 3);
      idle(4'd0, 16'h0000, 3);

      // Bank isolation: r5 written in bank 1, read in bank 0
      step(1'b1, 4'd0, 4'd0, 2'b00, 4'd5, 2'b10, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 3);
      step(1'b1, 4'd5, 4'd0, 2'b01, 4'd0, 2'b00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 3);
      idle(4'd1, 16'h0020, 3);
      idle(4'd1, 16'h0020, 3);
      idle(4'd1, 16'h0000, 3);

      // Hold for 2 cycles in the middle of the stall; src2 path used by the consumer
      step(1'b1, 4'd1, 4'd0, 2'b01, 4'd3, 2'b01, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 3);
      step(1'b1, 4'd0, 4'd3, 2'b10, 4'd4, 2'b01, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0008, 3);
      step(1'b1, 4'd0, 4'd3, 2'b10, 4'd4, 2'b01, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0008, 4);
      step(1'b1, 4'd0, 4'd3, 2'b10, 4'd4, 2'b01, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0008, 4);
      step(1'b1, 4'd0, 4'd3, 2'b10, 4'd4, 2'b01, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0008, 4);
      step(1'b1, 4'd0, 4'd3, 2'b10, 4'd4, 2'b01, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0008, 5);
      step(1'b1, 4'd0, 4'd3, 2'b10, 4'd4, 2'b01, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 6);
      idle(4'd0, 16'h0010, 6);
      idle(4'd0, 16'h0010, 6);
      idle(4'd0, 16'h0010, 6);

      // Flushed r7 writer leaves a bubble; following r7 read sees no hazard
      step(1'b1, 4'd0, 4'd0, 2'b00, 4'd7, 2'b01, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 6);
      step(1'b1, 4'd7, 4'd0, 2'b01, 4'd0, 2'b00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 6);

      // Flush coincident with a real hazard: masked, no count
      step(1'b1, 4'd1, 4'd0, 2'b01, 4'd3, 2'b01, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 6);
      step(1'b1, 4'd3, 4'd0, 2'b01, 4'd4, 2'b01, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0008, 6);
      idle(4'd0, 16'h0008, 6);
      idle(4'd0, 16'h0008, 6);
      idle(4'd0, 16'h0000, 6);

      // Asynchronous reset with a tag in flight
      step(1'b1, 4'd1, 4'd0, 2'b01, 4'd3, 2'b01, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 6);
      step(1'b0, 4'd0, 4'd0, 2'b00, 4'd0, 2'b00, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 0);
      idle(4'd0, 16'h0000, 0);

      // 21 hazard cycles: 16-bit counter reaches 21, 4-bit counter pins at 15
      for (int c = 0; c < 7; c++) sat_chain(3 * c);
      idle(4'd0, 16'h0000, 21);

      @(negedge clk_i);
      #1;
      chk("queue_drained", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
